// File: rtl/scan_sel_ctrl_if.sv
// Purpose: request/grant bundle between requesters and the round-robin scan sequencer.
// Latency: none, wires only.
// Backpressure: none carried here; hold is the only stall and travels with req.
// Ports: req[7:0], hold (toward sequencer); sel[2:0], sel_en, grant_done, busy (from sequencer).
interface scan_sel_ctrl_if;
  logic [7:0] req;
  logic       hold;
  logic [2:0] sel;
  logic       sel_en;
  logic       grant_done;
  logic       busy;

  // master drives the requests, slave is the sequencer
  modport master (
    output req, hold,
    input  sel, sel_en, grant_done, busy
  );

  modport slave (
    input  req, hold,
    output sel, sel_en, grant_done, busy
  );
endinterface

// File: rtl/scan_sel_ctrl.sv
// Purpose: round-robin scan sequencer driving index/enable into a 3-to-8 enabled decoder.
// Latency: 1 cycle from req to sel_en; each grant lasts DWELL cycles, then GAP dead cycles.
// Backpressure: hold freezes the dwell/gap counters and blocks new grants; no req ack.
// Ports: clk, rst (sync, active-high); bus.slave carries req[7:0], hold in and
//        sel[2:0], sel_en, grant_done (1-cycle pulse after a grant), busy out.
module scan_sel_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic          clk,
  input  logic          rst,
  scan_sel_ctrl_if.slave bus
);

  localparam logic [7:0] DWELL_LD = 8'(DWELL - 1);
  // GAP_LD is only used when HAS_GAP is set, so the GAP=0 wrap is harmless
  localparam logic [7:0] GAP_LD   = 8'(GAP - 1);
  localparam bit         HAS_GAP  = (GAP != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP_ST = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] ptr;
  logic [2:0] sel_q;
  logic       sel_en_q;
  logic       grant_done_q;
  logic       busy_q;

  logic       found;
  logic [2:0] win;

  // First set request at or after ptr, modulo 8. Walking the offsets from
  // high to low lets the smallest offset overwrite the others.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int i = 7; i >= 0; i--) begin
      if (bus.req[ptr + 3'(i)]) begin
        found = 1'b1;
        win   = ptr + 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      ptr          <= 3'd0;
      sel_q        <= 3'd0;
      sel_en_q     <= 1'b0;
      grant_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      grant_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !bus.hold) begin
            sel_q    <= win;
            sel_en_q <= 1'b1;
            cnt      <= DWELL_LD;
            ptr      <= win + 3'd1;
            state    <= ACTIVE;
            busy_q   <= 1'b1;
          end
        end

        ACTIVE: begin
          if (!bus.hold) begin
            if (cnt != 8'd0) begin
              cnt <= cnt - 8'd1;
            end else begin
              grant_done_q <= 1'b1;
              if (HAS_GAP) begin
                sel_en_q <= 1'b0;
                cnt      <= GAP_LD;
                state    <= GAP_ST;
              end else if (found) begin
                // back-to-back grant: sel_en stays high, only sel moves
                sel_q <= win;
                ptr   <= win + 3'd1;
                cnt   <= DWELL_LD;
              end else begin
                sel_en_q <= 1'b0;
                state    <= IDLE;
                busy_q   <= 1'b0;
              end
            end
          end
        end

        GAP_ST: begin
          if (!bus.hold) begin
            if (cnt != 8'd0) begin
              cnt <= cnt - 8'd1;
            end else if (found) begin
              sel_q    <= win;
              sel_en_q <= 1'b1;
              cnt      <= DWELL_LD;
              ptr      <= win + 3'd1;
              state    <= ACTIVE;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end

        default: begin
          state    <= IDLE;
          sel_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sel_en     = sel_en_q;
  assign bus.grant_done = grant_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_scan_sel_ctrl.sv
// Purpose: directed bench for scan_sel_ctrl with hand-computed expectations.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: hold is driven directly by the bench.
module tb_scan_sel_ctrl;
  logic clk;
  logic rst;

  scan_sel_ctrl_if i0 ();
  scan_sel_ctrl_if i1 ();

  scan_sel_ctrl #(.DWELL(4), .GAP(1)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
  scan_sel_ctrl #(.DWELL(2), .GAP(0)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

  int n_chk  = 0;
  int n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // One DWELL=4/GAP=1 grant on dut0: the next edge must start it, req moves
  // to nxt after the first active cycle, and the gap cycle must pulse done.
  task automatic grant0(input int exp, input logic [7:0] nxt, input string tag);
    step();
    chk({tag, "_sel"}, int'(i0.sel), exp);
    chk({tag, "_en"}, int'(i0.sel_en), 1);
    i0.req = nxt;
    for (int c = 1; c < 4; c++) begin
      step();
      chk({tag, "_hold_sel"}, int'(i0.sel), exp);
      chk({tag, "_hold_en"}, int'({i0.sel_en, i0.grant_done}), 2);
    end
    step();
    chk({tag, "_gap"}, int'({i0.sel_en, i0.grant_done, i0.busy}), 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n_en;
    int stable;
    int done_seen;

    rst     = 1'b1;
    i0.req  = 8'h00;
    i0.hold = 1'b0;
    i1.req  = 8'h00;
    i1.hold = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset", int'({i0.sel, i0.sel_en, i0.busy, i0.grant_done}), 0);

    // idle with no requests
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("idle%0d", k), int'({i0.sel, i0.sel_en, i0.busy, i0.grant_done}), 0);
    end

    // single request pulse on channel 2
    i0.req = 8'h04;
    grant0(2, 8'h00, "single");
    step();
    chk("single_idle", int'({i0.busy, i0.grant_done, i0.sel_en}), 0);
    chk("single_sel_kept", int'(i0.sel), 2);

    // all requesting: 0..7 then wrap to 0
    i0.req = 8'hFF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int g = 0; g < 8; g++) grant0(g, 8'hFF, $sformatf("rr%0d", g));
    grant0(0, 8'h40, "rr_wrap");

    // wrap from ptr=7: 7 then 1, then 5 from ptr=2
    grant0(6, 8'h82, "w6");
    grant0(7, 8'h82, "w7");
    grant0(1, 8'h20, "w1");
    grant0(5, 8'h00, "w5");
    step();
    chk("w_idle", int'(i0.busy), 0);

    // hold blocks a new grant from IDLE
    i0.hold = 1'b1;
    i0.req  = 8'h01;
    step();
    step();
    chk("hold_idle", int'({i0.sel_en, i0.busy}), 0);
    i0.hold = 1'b0;

    // hold for 3 cycles from the 2nd active cycle stretches the grant to 7
    step();
    i0.req    = 8'h00;
    n_en      = 0;
    stable    = 1;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (i0.sel_en) begin
        n_en++;
        if (i0.sel != 3'd0) stable = 0;
      end else begin
        done_seen = int'(i0.grant_done);
        break;
      end
      if (k == 1) i0.hold = 1'b1;
      if (k == 4) i0.hold = 1'b0;
      step();
    end
    chk("hold_len", n_en, 7);
    chk("hold_sel", stable, 1);
    chk("hold_done", done_seen, 1);
    step();
    chk("hold_end_idle", int'(i0.busy), 0);

    // GAP=0, DWELL=2: back-to-back 0,0,1,1,0,0 with no dead cycle
    i1.req = 8'h03;
    step();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      chk($sformatf("b2b_sel%0d", k), int'(i1.sel), (k / 2) % 2);
      chk($sformatf("b2b_en%0d", k), int'(i1.sel_en), 1);
      chk($sformatf("b2b_done%0d", k), int'(i1.grant_done), (k == 2 || k == 4) ? 1 : 0);
    end

    // reset on what would be the last grant cycle: no done, ptr back to 0
    rst = 1'b1;
    step();
    chk("rst_mid", int'({i1.sel, i1.sel_en, i1.grant_done, i1.busy}), 0);
    rst = 1'b0;
    step();
    chk("rst_ptr_sel", int'(i1.sel), 0);
    chk("rst_ptr_en", int'(i1.sel_en), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
